fetch_ctrl: RTL

Sequencing controller for the instruction-fetch stage. Each cycle it decides whether the PC advances, whether the fetched instruction is squashed, and whether a redirect target replaces PC+1. It arbitrates between boot, halt, load-use stalls, instruction-memory wait states, and branch/jump redirects from ID and EX. A redirect that cannot be taken immediately is held until it can. Its outputs drive the IF stage's `IF_CTRL` (PCWrite), `IF_FLUSH`, `jpcAvail` and `JPC` inputs.

---
 rtl/fetch_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: boot hold, halt, load-use stall, IM wait states and ID/EX redirects with a pending-redirect hold.
// Performance counters are built only when FETCH_PERF_EN is defined.
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_ready,
  input  logic        ld_use_hazard,
  input  logic        id_jump,
  input  logic [29:0] id_target,
  input  logic        ex_redirect,
  input  logic [29:0] ex_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic        PCWrite,
  output logic        IF_FLUSH,
  output logic        id_flush,
  output logic        jpcAvail,
  output logic [29:0] JPC,
  output logic [31:0] stall_cnt,
  output logic [31:0] redir_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state;
  logic [3:0]  boot_cnt;
  logic        pend_v;
  logic [29:0] pend_pc;
  logic        id_take;
  logic        redir_any;
  logic [29:0] redir_pc;

  always_comb begin
    id_take   = id_jump & ~ld_use_hazard;
    redir_any = ex_redirect | pend_v | id_take;
    redir_pc  = ex_redirect ? ex_target : (pend_v ? pend_pc : id_target);
    PCWrite   = 1'b0;
    IF_FLUSH  = 1'b1;
    jpcAvail  = 1'b0;
    JPC       = '0;
    if (state == RUN) begin
      // A redirect overrides a load-use stall: the stalled instruction is being discarded anyway.
      PCWrite  = im_ready & (~ld_use_hazard | ex_redirect | pend_v);
      jpcAvail = PCWrite & redir_any;
      JPC      = redir_any ? redir_pc : '0;
      IF_FLUSH = redir_any;
    end
  end

  assign id_flush = ex_redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      boot_cnt <= '0;
      pend_v   <= 1'b0;
      pend_pc  <= '0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 4'd1;
          if (boot_cnt == BOOT_LAST) state <= RUN;
        end
        RUN: begin
          if (PCWrite) begin
            pend_v <= 1'b0;
          end else if (ex_redirect) begin
            pend_v  <= 1'b1;
            pend_pc <= ex_target;
          end else if (id_take && !pend_v) begin
            pend_v  <= 1'b1;
            pend_pc <= id_target;
          end
          if (halt_req) state <= HALT;
        end
        HALT: begin
          if (ex_redirect) begin
            pend_v  <= 1'b1;
            pend_pc <= ex_target;
          end
          if (resume) state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (state == RUN && !PCWrite) stall_cnt <= stall_cnt + 32'd1;
      if (jpcAvail) redir_cnt <= redir_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign redir_cnt = '0;
`endif

endmodule
